// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared SPI master constants, defaults and FSM state encoding.
package spi_master_pkg;
   localparam int DIV_WIDTH         = 8;
   localparam int SPI_MAX_WIDTH_LOG = 4;
   localparam logic CPOL_LOW   = 1'b0;
   localparam logic CPOL_HIGH  = 1'b1;
   localparam logic CPHA_LEAD  = 1'b0;
   localparam logic CPHA_TRAIL = 1'b1;
   typedef enum logic [2:0] {IDLE, START, SETUP, RUN, HOLD, DONE} state_t;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: counts 0..i_div while enabled and flags the terminal count.
module spi_clk_div #(
   parameter int DIV_WIDTH = spi_master_pkg::DIV_WIDTH
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_en,
   input  logic                 i_clr,
   input  logic [DIV_WIDTH-1:0] i_div,
   output logic                 o_tick
);
   logic [DIV_WIDTH-1:0] r_cnt;
   assign o_tick = i_en && (r_cnt == i_div);
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en) r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
   end
endmodule

// File: rtl/spi_control_master.sv
// spi_control_master: SPI master control path - FSM, sck/cs_n generation and datapath strobes.
// Define SPI_CS_DELAY_EN to add clk_div+1 cycle cs_n setup/hold windows around the sck burst.
module spi_control_master #(
   parameter int SPI_MAX_WIDTH_LOG = spi_master_pkg::SPI_MAX_WIDTH_LOG,
   parameter int DIV_WIDTH         = spi_master_pkg::DIV_WIDTH
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_req,
   input  logic                         i_cpol,
   input  logic                         i_cpha,
   input  logic [DIV_WIDTH-1:0]         i_clk_div,
   input  logic [SPI_MAX_WIDTH_LOG-1:0] i_spi_width,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_spi_start,
   output logic                         o_sck_first_edge,
   output logic                         o_sck_second_edge,
   output logic                         o_sck,
   output logic                         o_cs_n
);
   import spi_master_pkg::*;
   state_t r_state, w_next;
   logic r_cpol, r_cpha, r_busy, r_done, r_start, r_first, r_second, r_sck, r_cs_n;
   logic [DIV_WIDTH-1:0] r_div;
   logic [SPI_MAX_WIDTH_LOG-1:0] r_width, r_bit;
   logic w_tick, w_en, w_lead, w_first, w_second;
   assign w_en   = r_state inside {SETUP, RUN, HOLD};
   assign w_lead = (r_state == RUN) && w_tick && (r_sck == r_cpol);
   spi_clk_div #(.DIV_WIDTH(DIV_WIDTH)) u_div (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (w_en),
      .i_clr   (!w_en),
      .i_div   (r_div),
      .o_tick  (w_tick)
   );
   always_comb begin
      w_next   = r_state;
      w_first  = 1'b0;
      w_second = 1'b0;
      case (r_state)
         IDLE:  w_next = i_req ? START : IDLE;
`ifdef SPI_CS_DELAY_EN
         START: w_next = SETUP;
         SETUP: w_next = w_tick ? RUN : SETUP;
         HOLD:  w_next = w_tick ? DONE : HOLD;
`else
         START: w_next = RUN;
`endif
         RUN: begin
            // bit 0 leading strobe is held back in cpha=1 so mosi stays on bit 0 for the first sample
            w_first  = w_lead && !(r_cpha == CPHA_TRAIL && r_bit == '0);
            w_second = w_tick && !w_lead;
`ifdef SPI_CS_DELAY_EN
            if (w_second && r_bit == r_width) w_next = HOLD;
`else
            if (w_second && r_bit == r_width) w_next = DONE;
`endif
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_cpol   <= 1'b0;
         r_cpha   <= 1'b0;
         r_div    <= '0;
         r_width  <= '0;
         r_bit    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_start  <= 1'b0;
         r_first  <= 1'b0;
         r_second <= 1'b0;
         r_sck    <= 1'b0;
         r_cs_n   <= 1'b1;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && i_req) begin
            r_cpol  <= i_cpol;
            r_cpha  <= i_cpha;
            r_div   <= i_clk_div;
            r_width <= i_spi_width;
         end
         r_bit    <= (r_state == RUN) ? r_bit + SPI_MAX_WIDTH_LOG'(w_second) : '0;
         r_busy   <= w_next != IDLE;
         r_done   <= w_next == DONE;
         r_start  <= w_next == START;
         r_first  <= w_first;
         r_second <= w_second;
         r_cs_n   <= (w_next == IDLE) || (w_next == DONE);
         r_sck    <= (r_state == IDLE) ? i_cpol :
                     (w_next == DONE) ? r_cpol :
                     (r_state == RUN && w_tick) ? ~r_sck : r_sck;
      end
   end
   assign o_busy            = r_busy;
   assign o_done            = r_done;
   assign o_spi_start       = r_start;
   assign o_sck_first_edge  = r_first;
   assign o_sck_second_edge = r_second;
   assign o_sck             = r_sck;
   assign o_cs_n            = r_cs_n;
endmodule

// File: tb/tb_spi_control_master.sv
// tb_spi_control_master: table-driven transfers checked by a done-time scoreboard, plus corner sequences.
module tb_spi_control_master;
   typedef struct {
      logic       cpol;
      logic       cpha;
      logic [7:0] div;
      logic [3:0] width;
      int         lat;
      int         n1;
      int         n2;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req = 1'b0, cpol = 1'b0, cpha = 1'b0;
   logic [7:0] clk_div = '0;
   logic [3:0] spi_width = '0;
   logic       busy, done, spi_start, first_edge, second_edge, sck, cs_n;

   int   checks = 0, errors = 0;
   int   cyc = 0, t_start = 0, n1 = 0, n2 = 0;
   bit   active = 0;
   vec_t vecs[8];
   vec_t sb[$];
   vec_t e;

   spi_control_master dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_req             (req),
      .i_cpol            (cpol),
      .i_cpha            (cpha),
      .i_clk_div         (clk_div),
      .i_spi_width       (spi_width),
      .o_busy            (busy),
      .o_done            (done),
      .o_spi_start       (spi_start),
      .o_sck_first_edge  (first_edge),
      .o_sck_second_edge (second_edge),
      .o_sck             (sck),
      .o_cs_n            (cs_n)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard: count strobes between spi_start and done, pop the expectation at done.
   always @(negedge clk) begin
      if (!rst_n) begin
         active = 0;
         n1 = 0;
         n2 = 0;
      end else begin
         if (spi_start) begin
            active = 1;
            n1 = 0;
            n2 = 0;
            t_start = cyc;
         end
         if (first_edge) n1++;
         if (second_edge) n2++;
         if (active && !done) begin
            if (cs_n !== 1'b0) chk("cs_n_low", int'(cs_n), 0);
            if (busy !== 1'b1) chk("busy_high", int'(busy), 1);
         end
         if (done) begin
            if (sb.size() == 0 || !active) chk("unexpected_done", 1, 0);
            else begin
               e = sb.pop_front();
               chk("latency", cyc - t_start + 1, e.lat);
               chk("first_edges", n1, e.n1);
               chk("second_edges", n2, e.n2);
               chk("done_sck", int'(sck), int'(e.cpol));
               chk("done_cs_n", int'(cs_n), 1);
               chk("done_busy", int'(busy), 1);
            end
            active = 0;
         end
      end
   end

   function automatic vec_t adj(input vec_t v);
      vec_t r = v;
`ifdef SPI_CS_DELAY_EN
      r.lat = r.lat + 2 * (int'(v.div) + 1);
`endif
      return r;
   endfunction

   task automatic wait_drain();
      for (int k = 0; k < 3000 && sb.size() != 0; k++) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      sb.delete();
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      cpol = v.cpol; cpha = v.cpha; clk_div = v.div; spi_width = v.width; req = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_sck", int'(sck), int'(v.cpol));
      req = 1'b1;
      @(posedge clk);
      sb.push_back(adj(v));
      @(negedge clk);
      req = 1'b0;
      chk("start_pulse", int'(spi_start), 1);
      chk("start_cs_n", int'(cs_n), 0);
      chk("start_sck", int'(sck), int'(v.cpol));
      wait_drain();
      repeat (2) @(negedge clk);
      chk("idle_busy", int'(busy), 0);
   endtask

   initial begin
      vec_t v;
      int   td;
      vecs[0] = '{1'b0, 1'b0, 8'd1, 4'd7,  34, 8,  8};
      vecs[1] = '{1'b1, 1'b1, 8'd0, 4'd3,  10, 3,  4};
      vecs[2] = '{1'b0, 1'b0, 8'd0, 4'd0,  4,  1,  1};
      vecs[3] = '{1'b0, 1'b1, 8'd0, 4'd0,  4,  0,  1};
      vecs[4] = '{1'b1, 1'b0, 8'd2, 4'd5,  38, 6,  6};
      vecs[5] = '{1'b0, 1'b0, 8'd0, 4'd15, 34, 16, 16};
      vecs[6] = '{1'b1, 1'b1, 8'd3, 4'd2,  26, 2,  3};
      vecs[7] = '{1'b0, 1'b1, 8'd7, 4'd1,  34, 1,  2};

      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_start", int'(spi_start), 0);
      chk("rst_first", int'(first_edge), 0);
      chk("rst_second", int'(second_edge), 0);
      chk("rst_sck", int'(sck), 0);
      chk("rst_cs_n", int'(cs_n), 1);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // req held high: ignored while busy, re-triggers right after DONE; mid-transfer clk_div change ignored
      v = adj('{1'b0, 1'b0, 8'd1, 4'd1, 10, 2, 2});
      @(negedge clk);
      cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1; spi_width = 4'd1; req = 1'b1;
      @(posedge clk);
      sb.push_back(v);
      sb.push_back(v);
      repeat (3) @(negedge clk);
      clk_div = 8'd5;
      repeat (2) @(negedge clk);
      clk_div = 8'd1;
      for (int k = 0; k < 200 && !done; k++) @(negedge clk);
      chk("held_done_seen", int'(done), 1);
      td = cyc;
      @(negedge clk);
      for (int k = 0; k < 10 && !spi_start; k++) @(negedge clk);
      chk("restart_gap", cyc - td, 2);
      req = 1'b0;
      wait_drain();

      // reset during RUN aborts with no done pulse
      @(negedge clk);
      cpol = 1'b0; cpha = 1'b0; clk_div = 8'd3; spi_width = 4'd7; req = 1'b1;
      @(posedge clk);
      sb.push_back(adj('{1'b0, 1'b0, 8'd3, 4'd7, 66, 8, 8}));
      @(negedge clk);
      req = 1'b0;
      repeat (8) @(negedge clk);
      chk("pre_abort_cs_n", int'(cs_n), 0);
      rst_n = 1'b0;
      #1;
      chk("abort_cs_n", int'(cs_n), 1);
      chk("abort_sck", int'(sck), 0);
      chk("abort_busy", int'(busy), 0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (80) @(negedge clk);
      run_vec(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
